// File: rtl/fp_fft_bf_sequencer_if.sv
// Control bus between the FFT butterfly sequencer and its surroundings:
// start/busy/done handshake, sample RAM / twiddle ROM read side,
// butterfly valids and the write-back side.
interface fp_fft_bf_sequencer_if #(
  parameter int unsigned LOG2N = 6
);
  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             bf_valid_in;
  logic             bf_valid_out;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic             err;

  // Sequencer side
  modport master (
    input  start, bf_valid_out,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_valid_in, wr_en, wr_addr_a, wr_addr_b, err
  );

  // Environment side (frame buffer control, RAM/ROM, butterfly)
  modport slave (
    output start, bf_valid_out,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_valid_in, wr_en, wr_addr_a, wr_addr_b, err
  );
endinterface

// File: rtl/fp_fft_bf_sequencer.sv
// Address/valid sequencer for an in-place radix-2 DIT FFT. Walks LOG2N
// stages of N/2 butterflies, issues read and twiddle addresses, and
// replays each read pair as the write-back pair when the butterfly
// result returns. Each stage drains fully before the next one reads.
module fp_fft_bf_sequencer #(
  parameter int unsigned N      = 64,
  parameter int unsigned LOG2N  = 6,
  parameter int unsigned BF_LAT = 0
) (
  input logic                   clk,
  input logic                   rst_n,
  fp_fft_bf_sequencer_if.master bus
);

  localparam int unsigned AW     = LOG2N;
  localparam int unsigned TW     = LOG2N - 1;
  localparam int unsigned KW     = LOG2N - 1;
  localparam int unsigned SW     = $clog2(LOG2N + 1);
  localparam int unsigned PD     = 1 + BF_LAT;
  localparam int unsigned DCW    = $clog2(BF_LAT + 2);
  localparam int unsigned HALF_N = N / 2;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [KW-1:0]  k_q, k_d;
  logic [DCW-1:0] dcnt_q, dcnt_d;

  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           rd_en_q, rd_en_d;
  logic [AW-1:0]  rd_addr_a_q, rd_addr_a_d;
  logic [AW-1:0]  rd_addr_b_q, rd_addr_b_d;
  logic [TW-1:0]  tw_addr_q, tw_addr_d;
  logic           bf_valid_in_q, bf_valid_in_d;
  logic           err_q, err_d;

  // Write-back address pipeline, one slot per cycle of butterfly latency
  logic [PD-1:0]  pv_q, pv_d;
  logic [AW-1:0]  pa_q [PD];
  logic [AW-1:0]  pa_d [PD];
  logic [AW-1:0]  pb_q [PD];
  logic [AW-1:0]  pb_d [PD];

  logic [AW-1:0]  kx, half, pos, grp, base, twx;

  // Next-state: stage/butterfly counters and drain timer
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ISSUE;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ISSUE: begin
        if (k_q == KW'(HALF_N - 1)) begin
          state_d = DRAIN;
          k_d     = '0;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DRAIN: begin
        if (dcnt_q == DCW'(BF_LAT)) begin
          if (s_q == SW'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            s_d     = s_q + SW'(1);
            k_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        s_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next outputs from next state: read addresses, status, write-back pipe
  always_comb begin
    half = AW'(1) << s_d;
    kx   = AW'(k_d);
    pos  = kx & (half - AW'(1));
    grp  = kx >> s_d;
    base = ((grp << s_d) << 1) | pos;
    twx  = pos << (SW'(TW) - s_d);

    rd_en_d       = (state_d == ISSUE);
    rd_addr_a_d   = rd_en_d ? base : '0;
    rd_addr_b_d   = rd_en_d ? (base | half) : '0;
    tw_addr_d     = rd_en_d ? TW'(twx) : '0;
    busy_d        = (state_d == ISSUE) || (state_d == DRAIN);
    done_d        = (state_d == DONE);
    bf_valid_in_d = rd_en_q;
    // A result with no matching issued pair is a protocol error
    err_d         = err_q | (bus.bf_valid_out & ~pv_q[PD-1]);

    pv_d[0] = rd_en_q;
    pa_d[0] = rd_addr_a_q;
    pb_d[0] = rd_addr_b_q;
    for (int i = 1; i < int'(PD); i++) begin
      pv_d[i] = pv_q[i-1];
      pa_d[i] = pa_q[i-1];
      pb_d[i] = pb_q[i-1];
    end
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      s_q           <= '0;
      k_q           <= '0;
      dcnt_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_a_q   <= '0;
      rd_addr_b_q   <= '0;
      tw_addr_q     <= '0;
      bf_valid_in_q <= 1'b0;
      err_q         <= 1'b0;
      pv_q          <= '0;
      for (int i = 0; i < int'(PD); i++) begin
        pa_q[i] <= '0;
        pb_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      s_q           <= s_d;
      k_q           <= k_d;
      dcnt_q        <= dcnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_en_q       <= rd_en_d;
      rd_addr_a_q   <= rd_addr_a_d;
      rd_addr_b_q   <= rd_addr_b_d;
      tw_addr_q     <= tw_addr_d;
      bf_valid_in_q <= bf_valid_in_d;
      err_q         <= err_d;
      pv_q          <= pv_d;
      pa_q          <= pa_d;
      pb_q          <= pb_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = rd_en_q;
  assign bus.rd_addr_a   = rd_addr_a_q;
  assign bus.rd_addr_b   = rd_addr_b_q;
  assign bus.tw_addr     = tw_addr_q;
  assign bus.bf_valid_in = bf_valid_in_q;
  // Write strobe follows the butterfly directly so results land before
  // the next stage's first read.
  assign bus.wr_en       = bus.bf_valid_out;
  assign bus.wr_addr_a   = pa_q[PD-1];
  assign bus.wr_addr_b   = pb_q[PD-1];
  assign bus.err         = err_q;

endmodule

// File: tb/tb_fp_fft_bf_sequencer.sv
// Scoreboard bench: two sequencers (N=8, butterfly latency 0 and 3).
// Stimulus pushes expected read/write/done events with their cycle;
// a monitor pops and compares whenever the DUT presents them.
module tb_fp_fft_bf_sequencer;
  localparam int unsigned N     = 8;
  localparam int unsigned LOG2N = 3;
  localparam int          L1    = 3;

  typedef struct {
    int cyc;
    int a;
    int b;
    int tw;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       start0, start1, spur;
  logic [2:0] dl;

  int  cyc = 0;
  int  total = 0;
  int  bad = 0;
  int  cur;
  bit  err_mode, mon_on;
  int  busy_lo [2];
  int  busy_hi [2];
  ev_t rdq [$];
  ev_t wrq [$];
  int  dq  [$];

  // Hand-computed N=8 pair/twiddle sequence, stages 0..2
  int ta [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int tb [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int tt [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  fp_fft_bf_sequencer_if #(.LOG2N(LOG2N)) if0 ();
  fp_fft_bf_sequencer_if #(.LOG2N(LOG2N)) if1 ();

  fp_fft_bf_sequencer #(.N(N), .LOG2N(LOG2N), .BF_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  fp_fft_bf_sequencer #(.N(N), .LOG2N(LOG2N), .BF_LAT(L1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  assign if0.start        = start0;
  assign if1.start        = start1;
  assign if0.bf_valid_out = if0.bf_valid_in | spur;
  always @(posedge clk) begin
    if (!rst_n) dl <= '0;
    else        dl <= {dl[1:0], if1.bf_valid_in};
  end
  assign if1.bf_valid_out = dl[2] | spur;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int i);
    return (i == 0) ? 0 : L1;
  endfunction

  function automatic int per(input int i);
    return int'(N / 2) + 1 + lat(i);
  endfunction

  function automatic logic [19:0] outs(input int i);
    if (i == 0)
      return {if0.busy, if0.done, if0.rd_en, if0.rd_addr_a, if0.rd_addr_b, if0.tw_addr,
              if0.bf_valid_in, if0.wr_en, if0.wr_addr_a, if0.wr_addr_b, if0.err};
    return {if1.busy, if1.done, if1.rd_en, if1.rd_addr_a, if1.rd_addr_b, if1.tw_addr,
            if1.bf_valid_in, if1.wr_en, if1.wr_addr_a, if1.wr_addr_b, if1.err};
  endfunction

  function automatic logic err_of(input int i);
    return (i == 0) ? if0.err : if1.err;
  endfunction

  task automatic chk(input bit ok, input string msg);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic set_start(input int i, input logic v);
    if (i == 0) start0 = v;
    else        start1 = v;
  endtask

  task automatic mon(input int i, input logic busy, input logic done, input logic rd_en,
                     input logic [2:0] ra, input logic [2:0] rb, input logic [1:0] tw,
                     input logic wr_en, input logic [2:0] wa, input logic [2:0] wb,
                     input logic err);
    ev_t e;
    bit  eb;
    int  dc;
    eb = (cyc >= busy_lo[i]) && (cyc <= busy_hi[i]);
    chk(busy === eb, $sformatf("busy_%0d cyc=%0d got %0b expected %0b", i, cyc, busy, eb));
    if (rd_en !== 1'b0) begin
      if (i != cur || rdq.size() == 0)
        chk(1'b0, $sformatf("rd_unexpected_%0d cyc=%0d got (%0d,%0d) expected none", i, cyc, ra, rb));
      else begin
        e = rdq.pop_front();
        chk(e.cyc == cyc && ra == e.a && rb == e.b && tw == e.tw,
            $sformatf("rd_%0d got cyc=%0d (%0d,%0d) tw=%0d expected cyc=%0d (%0d,%0d) tw=%0d",
                      i, cyc, ra, rb, tw, e.cyc, e.a, e.b, e.tw));
      end
    end else begin
      chk(ra == 0 && rb == 0 && tw == 0,
          $sformatf("rd_addr_idle_%0d cyc=%0d got (%0d,%0d) tw=%0d expected zeros", i, cyc, ra, rb, tw));
    end
    if (wr_en !== 1'b0 && !spur) begin
      if (i != cur || wrq.size() == 0)
        chk(1'b0, $sformatf("wr_unexpected_%0d cyc=%0d got (%0d,%0d) expected none", i, cyc, wa, wb));
      else begin
        e = wrq.pop_front();
        chk(e.cyc == cyc && wa == e.a && wb == e.b,
            $sformatf("wr_%0d got cyc=%0d (%0d,%0d) expected cyc=%0d (%0d,%0d)",
                      i, cyc, wa, wb, e.cyc, e.a, e.b));
      end
    end
    if (done !== 1'b0) begin
      if (i != cur || dq.size() == 0)
        chk(1'b0, $sformatf("done_unexpected_%0d cyc=%0d got pulse expected none", i, cyc));
      else begin
        dc = dq.pop_front();
        chk(dc == cyc, $sformatf("done_%0d got cyc=%0d expected cyc=%0d", i, cyc, dc));
      end
    end
    if (!err_mode)
      chk(err === 1'b0, $sformatf("err_%0d cyc=%0d got %0b expected 0", i, cyc, err));
  endtask

  // Monitor: sample just after each active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        mon(0, if0.busy, if0.done, if0.rd_en, if0.rd_addr_a, if0.rd_addr_b, if0.tw_addr,
            if0.wr_en, if0.wr_addr_a, if0.wr_addr_b, if0.err);
        mon(1, if1.busy, if1.done, if1.rd_en, if1.rd_addr_a, if1.rd_addr_b, if1.tw_addr,
            if1.wr_en, if1.wr_addr_a, if1.wr_addr_b, if1.err);
      end
    end
  end

  // Drive start at a negedge and queue the full expected run
  task automatic do_start(input int i, output int c0);
    ev_t e;
    int  p;
    p  = per(i);
    c0 = cyc + 1;
    for (int s = 0; s < int'(LOG2N); s++) begin
      for (int k = 0; k < int'(N / 2); k++) begin
        e.cyc = c0 + s * p + k;
        e.a   = ta[s * 4 + k];
        e.b   = tb[s * 4 + k];
        e.tw  = tt[s * 4 + k];
        rdq.push_back(e);
        e.cyc = e.cyc + 1 + lat(i);
        wrq.push_back(e);
      end
    end
    dq.push_back(c0 + int'(LOG2N) * p);
    busy_lo[i] = c0;
    busy_hi[i] = c0 + int'(LOG2N) * p - 1;
    cur = i;
    set_start(i, 1'b1);
    @(negedge clk);
    set_start(i, 1'b0);
  endtask

  task automatic pulse_ignored(input int i);
    set_start(i, 1'b1);
    @(negedge clk);
    set_start(i, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rdq.size() != 0 || wrq.size() != 0 || dq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(n < 400, $sformatf("drain_timeout got %0d cycles expected <400", n));
    repeat (3) @(negedge clk);
  endtask

  // Full run with starts in busy and DONE cycles, then back-to-back rerun
  task automatic run_basic(input int i);
    int c0, c1;
    do_start(i, c0);
    repeat (3) @(negedge clk);
    pulse_ignored(i);
    while (cyc < c0 + int'(LOG2N) * per(i)) @(negedge clk);
    pulse_ignored(i);
    do_start(i, c1);
    chk(c1 == c0 + int'(LOG2N) * per(i) + 2,
        $sformatf("rerun_start_%0d got c=%0d expected c=%0d", i, c1, c0 + int'(LOG2N) * per(i) + 2));
    wait_idle();
  endtask

  // Reset in the middle of stage 1, then a clean full run
  task automatic rst_mid(input int i);
    int c0;
    do_start(i, c0);
    while (cyc < c0 + per(i) + 3) @(negedge clk);
    rdq.delete();
    wrq.delete();
    dq.delete();
    busy_hi[i] = cyc;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk(outs(i) === 20'd0, $sformatf("midrun_reset_%0d got %05h expected 00000", i, outs(i)));
    repeat (2) @(negedge clk);
    do_start(i, c0);
    wait_idle();
  endtask

  initial begin
    rst_n    = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    spur     = 1'b0;
    err_mode = 1'b0;
    mon_on   = 1'b0;
    cur      = -1;
    busy_lo  = '{1, 1};
    busy_hi  = '{0, 0};
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk(outs(i) === 20'd0, $sformatf("reset_state_%0d got %05h expected 00000", i, outs(i)));
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      run_basic(i);
      rst_mid(i);
    end

    // Spurious butterfly result while idle sets the sticky error
    cur      = -1;
    err_mode = 1'b1;
    spur     = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    for (int i = 0; i < 2; i++)
      chk(err_of(i) === 1'b1, $sformatf("err_set_%0d got %0b expected 1", i, err_of(i)));
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk(err_of(i) === 1'b1, $sformatf("err_sticky_%0d got %0b expected 1", i, err_of(i)));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++)
      chk(err_of(i) === 1'b0, $sformatf("err_reset_%0d got %0b expected 0", i, err_of(i)));
    err_mode = 1'b0;
    repeat (3) @(negedge clk);

    chk(rdq.size() == 0 && wrq.size() == 0 && dq.size() == 0,
        $sformatf("queues_drained got rd=%0d wr=%0d done=%0d expected 0", rdq.size(), wrq.size(), dq.size()));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/fp_fft_bf_sequencer.md
Name: fp_fft_bf_sequencer

Overview:
- Control master for an in-place radix-2 DIT FFT.
- Issues read addresses to a dual-read-port sample RAM and a twiddle ROM, and drives valid_in into the fp_butterfly datapath.
- Takes the butterfly's valid_out and issues write-back addresses so C/D results overwrite the A/B locations.
- Sits between the STFT frame buffer and fp_butterfly. Input data is already in bit-reversed order; the block only moves addresses and valids, never data.

Parameters:
- N, 64, FFT size; power of 2, N >= 4.
- LOG2N, 6, log2(N).
- BF_LAT, 0, butterfly latency in cycles from valid_in to valid_out (0 = combinational).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to run the full FFT; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the last write-back completes.
- rd_en  output  1  sample RAM read strobe; read data returns 1 cycle later.
- rd_addr_a  output  LOG2N  A operand address.
- rd_addr_b  output  LOG2N  B operand address.
- tw_addr  output  LOG2N-1  twiddle ROM index j (ROM holds W_N^j, 1-cycle latency).
- bf_valid_in  output  1  to fp_butterfly valid_in; equals rd_en delayed 1 cycle.
- bf_valid_out  input  1  from fp_butterfly valid_out.
- wr_en  output  1  write strobe for C->addr_a and D->addr_b.
- wr_addr_a  output  LOG2N  C write address.
- wr_addr_b  output  LOG2N  D write address.
- err  output  1  sticky: bf_valid_out arrived with no matching pending write. Cleared only by reset.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - FSM goes to IDLE; stage s=0, butterfly count k=0.
  - The address delay pipeline is flushed.
  - All outputs are 0, including err.
  - Reset mid-run abandons the FFT; no further rd_en or wr_en is issued.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: start=1 -> ISSUE with s=0, k=0.
  - ISSUE: rd_en=1 every cycle; k increments each cycle. At k=N/2-1, go to DRAIN.
  - DRAIN: rd_en=0; a counter runs 1+BF_LAT cycles. On its last cycle:
    - if s=LOG2N-1 -> DONE;
    - else s increments, k=0 -> ISSUE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- busy=1 in ISSUE and DRAIN; busy=0 in IDLE and DONE.
- start is ignored in ISSUE, DRAIN and DONE.
- Address generation in ISSUE:
  - half=2^s; group=k>>s; pos=k&(half-1).
  - rd_addr_a=group*2*half+pos; rd_addr_b=rd_addr_a+half.
  - tw_addr=pos<<(LOG2N-1-s).
  - rd_addr_a, rd_addr_b and tw_addr are 0 when rd_en=0.
- Write-back pipeline:
  - Each issued (addr_a, addr_b) pair plus a valid bit enters a shift pipeline of depth 1+BF_LAT.
  - wr_en=bf_valid_out. wr_addr_a/wr_addr_b = pipeline output.
  - If bf_valid_out=1 while the pipeline output valid bit is 0, set err. wr_en still follows bf_valid_out.
- Hazard rule: the next stage issues nothing until the DRAIN of the current stage has covered every write-back. This guarantees read-after-write ordering between stages.
- Timing:
  - Each stage takes N/2+1+BF_LAT cycles.
  - done asserts LOG2N*(N/2+1+BF_LAT)+1 cycles after the start-accept edge.
  - Example: N=8, BF_LAT=0 gives 16 cycles.
- Throughput: one butterfly per cycle during ISSUE; no back-pressure.

Test Plan:
- N=8, BF_LAT=0, bench echoes bf_valid_in as bf_valid_out; pulse start. Required response:
  - s0 pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0.
  - s1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2.
  - s2 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3.
  - done exactly 16 cycles after start; busy high for 15 cycles; err=0.
- Write-back check: every wr_en pair equals the rd pair issued 1+BF_LAT cycles earlier. Run with BF_LAT=0 and BF_LAT=3 (N=8, done at cycle 25).
- Stage isolation: with BF_LAT=3, no rd_en occurs while any write-back from the previous stage is pending. The gap between stages is 4 cycles.
- start pulsed during busy, and again in the DONE cycle -> ignored; exactly one done pulse. A start one cycle after done launches a second identical run.
- rst_n=0 mid-stage 1 -> next cycle busy=0, rd_en=0, wr_en=0. A later start runs a full correct sequence from s0.
- Spurious bf_valid_out=1 in IDLE -> err=1 and stays 1 until rst_n=0.
